down_timer: RTL and testbench

// Loadable countdown timer; the decrementing counterpart of the up-counter with

---
 rtl/down_timer.sv | 139 +++++++++++++
 tb/tb_down_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable countdown timer with a valid/ready load handshake.
// A loaded count runs down to zero. Reaching zero raises a one-cycle expire pulse.
// In one-shot mode the timer then parks in DONE with a sticky done flag until it
// is acknowledged. In periodic mode it reloads and keeps counting.
// pause_i freezes the count and abort_i cancels a count at any time.
module down_timer #(
  parameter  int Limit = 16,
  localparam int Width = $clog2(Limit)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [Width-1:0] load_value_i,
  input  logic             auto_reload_i,
  input  logic             pause_i,
  input  logic             abort_i,
  input  logic             done_ack_i,
  output logic [Width-1:0] value_o,
  output logic             busy_o,
  output logic             expire_o,
  output logic             done_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StPaused = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  // Largest legal count. Held one bit wider so the saturation compare is not
  // constant-folded when Limit is a power of two.
  localparam logic [Width:0] MaxWide = (Width+1)'(Limit - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [Width-1:0] value_next;
  logic [Width-1:0] reload;
  logic [Width-1:0] reload_next;
  logic             auto;
  logic             auto_next;
  logic             expire_next;
  logic             done_next;
  logic             handshake;
  logic [Width:0]   load_wide;
  logic [Width-1:0] load_sat;

  assign load_ready_o = (state == StIdle);
  assign busy_o       = (state == StRun) || (state == StPaused);
  assign handshake    = load_valid_i && load_ready_o;
  assign load_wide    = {1'b0, load_value_i};
  assign load_sat     = (load_wide > MaxWide) ? MaxWide[Width-1:0] : load_value_i;

  // Next-state and next-output decision for every state.
  // RUN and PAUSED share one branch: an un-paused cycle counts.
  // So leaving PAUSED decrements on that same edge, and a pause of P cycles
  // delays expiry by exactly P cycles.
  always_comb begin
    state_next  = state;
    value_next  = value_o;
    reload_next = reload;
    auto_next   = auto;
    expire_next = 1'b0;
    done_next   = done_o;

    case (state)
      StIdle: begin
        if (handshake) begin
          value_next  = load_sat;
          reload_next = load_sat;
          auto_next   = auto_reload_i;
          if (load_sat == '0) begin
            // A zero load expires immediately. It never starts a zero-period loop.
            expire_next = 1'b1;
            if (!auto_reload_i) begin
              state_next = StDone;
              done_next  = 1'b1;
            end
          end else begin
            state_next = StRun;
          end
        end
      end

      StRun, StPaused: begin
        if (abort_i) begin
          state_next = StIdle;
          value_next = '0;
        end else if (pause_i) begin
          state_next = StPaused;
        end else begin
          state_next = StRun;
          if (value_o != '0) begin
            value_next  = value_o - Width'(1);
            expire_next = (value_o == Width'(1));
          end else if (auto) begin
            value_next = reload;
          end else begin
            state_next = StDone;
            done_next  = 1'b1;
          end
        end
      end

      StDone: begin
        value_next = '0;
        if (done_ack_i || abort_i) begin
          state_next = StIdle;
          done_next  = 1'b0;
        end
      end

      default: begin
        state_next = StIdle;
        value_next = '0;
        done_next  = 1'b0;
      end
    endcase
  end

  // All timer state and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= StIdle;
      value_o  <= '0;
      reload   <= '0;
      auto     <= 1'b0;
      expire_o <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_next;
      value_o  <= value_next;
      reload   <= reload_next;
      auto     <= auto_next;
      expire_o <= expire_next;
      done_o   <= done_next;
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Testbench for down_timer (Limit = 10, so loads above 9 saturate).
// Every cycle's outputs are compared with a cycle-level reference model.
// The model tracks a phase and a remaining count as plain integers.
module tb_down_timer;

  localparam int Limit = 10;
  localparam int Width = $clog2(Limit);
  localparam int MaxValue = Limit - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [Width-1:0] load_value = '0;
  logic             auto_reload = 1'b0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic             done_ack = 1'b0;
  logic [Width-1:0] value;
  logic             busy;
  logic             expire;
  logic             done;

  int numChecks = 0;
  int numFails = 0;

  // Reference model: phase 0 = waiting for a load, 1 = counting (paused or not),
  // 2 = finished one-shot.
  int mPhase = 0;
  int mCount = 0;
  int mPeriod = 0;
  bit mPeriodic = 1'b0;
  bit mExpire = 1'b0;

  down_timer #(.Limit(Limit)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_value_i (load_value),
    .auto_reload_i(auto_reload),
    .pause_i      (pause),
    .abort_i      (abort),
    .done_ack_i   (done_ack),
    .value_o      (value),
    .busy_o       (busy),
    .expire_o     (expire),
    .done_o       (done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0;
    mCount = 0;
    mPeriod = 0;
    mPeriodic = 1'b0;
    mExpire = 1'b0;
  endtask

  // Advance the model by one clock edge, applying the timer rules directly.
  task automatic modelStep(input bit lv, input int lval, input bit ar,
                           input bit pz, input bit ab, input bit ack);
    mExpire = 1'b0;
    if (mPhase == 0) begin
      if (lv) begin
        mCount = (lval > MaxValue) ? MaxValue : lval;
        mPeriod = mCount;
        mPeriodic = ar;
        if (mCount == 0) begin
          mExpire = 1'b1;
          if (!ar) mPhase = 2;
        end else begin
          mPhase = 1;
        end
      end
    end else if (mPhase == 1) begin
      if (ab) begin
        mPhase = 0;
        mCount = 0;
      end else if (!pz) begin
        if (mCount > 0) begin
          mCount = mCount - 1;
          mExpire = (mCount == 0);
        end else if (mPeriodic) begin
          mCount = mPeriod;
        end else begin
          mPhase = 2;
        end
      end
    end else begin
      if (ack || ab) mPhase = 0;
    end
  endtask

  task automatic compareAll();
    checkOutput("value", int'(value), mCount);
    checkOutput("busy", int'(busy), int'(mPhase == 1));
    checkOutput("load_ready", int'(load_ready), int'(mPhase == 0));
    checkOutput("expire", int'(expire), int'(mExpire));
    checkOutput("done", int'(done), int'(mPhase == 2));
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic applyStimulus(input bit lv, input int lval, input bit ar,
                               input bit pz, input bit ab, input bit ack);
    load_valid = lv;
    load_value = Width'(lval);
    auto_reload = ar;
    pause = pz;
    abort = ab;
    done_ack = ack;
    @(posedge clk);
    modelStep(lv, lval, ar, pz, ab, ack);
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset away from a clock edge and check that it acts immediately.
  task automatic asyncReset(input string tag);
    load_valid = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    done_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, "_value"}, int'(value), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_expire"}, int'(expire), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_ready"}, int'(load_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compareAll();
  endtask

  int expCount;
  int firstExpire;

  initial begin
    $display("[TB] down_timer test start");
    modelReset();

    // Power-on reset.
    #3;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compareAll();

    // One-shot: load 3.
    applyStimulus(1, 3, 0, 0, 0, 0);
    checkOutput("oneshot_start", int'(value), 3);
    expCount = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (expire) expCount++;
    end
    checkOutput("oneshot_expire_at_zero", int'(expire && value == 0), 1);
    checkOutput("oneshot_expire_count", expCount, 1);
    idleCycles(3);
    checkOutput("oneshot_done_sticky", int'(done), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("oneshot_ready_after_ack", int'(load_ready), 1);

    // Periodic: load 2, auto-reload.
    applyStimulus(1, 2, 1, 0, 0, 0);
    expCount = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (expire) expCount++;
    end
    checkOutput("periodic_expire_count", expCount, 3);
    applyStimulus(0, 0, 0, 0, 1, 0);
    expCount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (expire) expCount++;
    end
    checkOutput("periodic_after_abort", expCount, 0);

    // Pause: load 4, pause for 5 cycles while the value is 2.
    applyStimulus(1, 4, 0, 0, 0, 0);
    firstExpire = -1;
    for (int k = 2; k <= 14; k++) begin
      applyStimulus(0, 0, 0, (k >= 4 && k <= 8), 0, 0);
      if (expire && firstExpire < 0) firstExpire = k;
    end
    checkOutput("pause_expiry_delay", firstExpire, 10);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 4, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("pause_abort_busy", int'(busy), 0);

    // Boundaries: zero load, saturation, ignored loads.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("zero_load_expire", int'(expire), 1);
    checkOutput("zero_load_done", int'(done), 1);
    applyStimulus(1, 7, 0, 0, 0, 0);
    checkOutput("load_in_done_ignored", int'(value), 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("zero_auto_stays_idle", int'(load_ready), 1);
    applyStimulus(1, 15, 0, 0, 0, 0);
    checkOutput("saturated_start", int'(value), MaxValue);
    applyStimulus(1, 3, 0, 0, 0, 0);
    checkOutput("load_in_run_ignored", int'(value), MaxValue - 1);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Reset mid-count at value 5.
    applyStimulus(1, 7, 0, 0, 0, 0);
    idleCycles(2);
    checkOutput("reset_precondition", int'(value), 5);
    asyncReset("midrun_reset");

    // Random traffic against the model, with an occasional async reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        asyncReset("random_reset");
      end else begin
        applyStimulus($urandom_range(0, 1) == 0, int'($urandom_range(0, 15)),
                      $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
